chunk_collector: RTL and testbench

CHUNK_COLLECTOR -- requirements
Module: chunk_collector

---
 rtl/chunk_collector.sv | 130 +++++++++++++
 tb/tb_chunk_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_collector.sv
// chunk_collector: ping-pong sample buffer that exposes each completed chunk on a read port.
// Optional overrun tracking is built only when CHUNK_OVERRUN_DETECT_EN is defined.
module chunk_collector #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_SIZE     = 64,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [SAMPLE_SIZE-1:0]      in_sample,
  input  logic                        proc_busy,
  input  logic [IO_BUFF_PTR_BITS-1:0] rd_ptr,
  output logic [SAMPLE_SIZE-1:0]      rd_sample,
  output logic                        chunk_pulse,
  output logic                        rd_bank,
  output logic                        overrun,
  output logic [7:0]                  overrun_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_PTR = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
  localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_ZERO = IO_BUFF_PTR_BITS'(0);
  localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_ONE  = IO_BUFF_PTR_BITS'(1);

  logic [SAMPLE_SIZE-1:0]      r_mem [2][IO_BUFF_SIZE];
  logic [0:0]                  r_state;
  logic [IO_BUFF_PTR_BITS-1:0] r_wr_ptr;
  logic                        r_wr_bank;
  logic                        r_rd_bank;
  logic                        r_chunk_pulse;
  logic                        w_at_last;
  logic                        w_write;
  logic                        w_complete;

  assign w_at_last  = (r_wr_ptr == LAST_PTR);
  // The completing write is honoured even if en drops in that same cycle.
  assign w_write    = ~rst & (r_state == ST_FILL) & in_valid & (en | w_at_last);
  assign w_complete = w_write & w_at_last;

  // Sample storage; deliberately excluded from reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_bank][r_wr_ptr] <= in_sample;
    end
  end

  // Capture FSM, write pointer and bank bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= PTR_ZERO;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_chunk_pulse <= 1'b0;
    end else begin
      r_chunk_pulse <= w_complete;
      case (r_state)
        ST_IDLE: begin
          // wr_bank is held: it is 0 until the first chunk, then always the non-read bank.
          r_wr_ptr <= PTR_ZERO;
          if (en) begin
            r_state <= ST_FILL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (w_complete) begin
            r_wr_ptr  <= PTR_ZERO;
            r_wr_bank <= ~r_wr_bank;
            r_rd_bank <= r_wr_bank;
          end else if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
          end else begin
            r_wr_ptr <= r_wr_ptr;
          end
          if (!en) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= PTR_ZERO;
          end else begin
            r_state <= ST_FILL;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_wr_ptr <= PTR_ZERO;
        end
      endcase
    end
  end

  assign rd_sample   = r_mem[r_rd_bank][rd_ptr];
  assign chunk_pulse = r_chunk_pulse;
  assign rd_bank     = r_rd_bank;

`ifdef CHUNK_OVERRUN_DETECT_EN
  logic       r_overrun;
  logic [7:0] r_overrun_count;

  // Sticky overrun flag and saturating event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun       <= 1'b0;
      r_overrun_count <= 8'd0;
    end else if (w_complete && proc_busy) begin
      r_overrun <= 1'b1;
      if (r_overrun_count != 8'd255) begin
        r_overrun_count <= r_overrun_count + 8'd1;
      end else begin
        r_overrun_count <= r_overrun_count;
      end
    end else begin
      r_overrun       <= r_overrun;
      r_overrun_count <= r_overrun_count;
    end
  end

  assign overrun       = r_overrun;
  assign overrun_count = r_overrun_count;
`else
  logic w_unused_proc_busy;
  assign w_unused_proc_busy = proc_busy;
  assign overrun            = 1'b0;
  assign overrun_count      = 8'd0;
`endif

endmodule

// File: tb/tb_chunk_collector.sv
// Scoreboard bench for chunk_collector: a queue-based reference model predicts every chunk,
// a monitor checks each chunk_pulse (timing, bank, overrun state and all read-port words).
module tb_chunk_collector;

  localparam int SS = 24;
  localparam int N  = 64;
`ifdef CHUNK_OVERRUN_DETECT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct packed {
    int            exp_cyc;
    logic          bank;
    logic          ovr;
    logic [7:0]    cnt;
    logic [N*SS-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [SS-1:0] in_sample;
  logic          proc_busy;
  logic [5:0]    rd_ptr;
  logic [SS-1:0] rd_sample;
  logic          chunk_pulse;
  logic          rd_bank;
  logic          overrun;
  logic [7:0]    overrun_count;

  chunk_collector #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(N)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sample(in_sample),
    .proc_busy(proc_busy), .rd_ptr(rd_ptr), .rd_sample(rd_sample),
    .chunk_pulse(chunk_pulse), .rd_bank(rd_bank), .overrun(overrun),
    .overrun_count(overrun_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  exp_t q[$];

  // reference model state: samples of the chunk in progress, chunks completed since reset
  logic [SS-1:0] m_cur[$];
  bit            m_armed;
  int            m_nchunks;
  bit            m_ovr;
  int            m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit v, input logic [SS-1:0] s, input bit b);
    exp_t it;
    if (r) begin
      m_cur.delete(); m_armed = 0; m_nchunks = 0; m_ovr = 0; m_cnt = 0;
    end else if (!m_armed) begin
      m_armed = e;
    end else begin
      if (v && (e || m_cur.size() == N - 1)) begin
        m_cur.push_back(s);
        if (m_cur.size() == N) begin
          if (OVR_EN && b) begin
            m_ovr = 1;
            if (m_cnt < 255) m_cnt++;
          end
          it.exp_cyc = cyc + 1;
          it.bank    = m_nchunks[0];
          it.ovr     = m_ovr;
          it.cnt     = 8'(m_cnt);
          for (int i = 0; i < N; i++) it.data[i*SS +: SS] = m_cur[i];
          q.push_back(it);
          m_nchunks++;
          m_cur.delete();
        end
      end
      if (!e) begin
        m_armed = 0;
        m_cur.delete();
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [SS-1:0] s, input bit b);
    @(negedge clk);
    rst = r; en = e; in_valid = v; in_sample = s; proc_busy = b;
    model(r, e, v, s, b);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) step(0, e, 0, '0, 0);
  endtask

  task automatic feed(input int n, input int base, input bit busy);
    for (int i = 0; i < n; i++) step(0, 1, 1, SS'(base + i), busy);
  endtask

  // monitor: every chunk_pulse is matched against the oldest predicted chunk
  initial begin
    exp_t it;
    rd_ptr = '0;
    forever begin
      @(negedge clk);
      if (chunk_pulse === 1'b1) begin
        pulses++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          it = q.pop_front();
          chk("pulse_cycle", cyc, it.exp_cyc);
          chk("pulse_rd_bank", {31'd0, rd_bank}, {31'd0, it.bank});
          chk("pulse_overrun", {31'd0, overrun}, {31'd0, it.ovr});
          chk("pulse_overrun_count", {24'd0, overrun_count}, {24'd0, it.cnt});
          for (int i = 0; i < N; i++) begin
            rd_ptr = 6'(i);
            #1;
            chk("rd_sample", {8'd0, rd_sample}, {8'd0, it.data[i*SS +: SS]});
          end
        end
      end else if (q.size() != 0 && q[0].exp_cyc <= cyc) begin
        chk("missing_pulse", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int p0;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_sample = '0; proc_busy = 1'b0;

    // reset state
    do_reset();
    idle(1, 0);
    chk("reset_chunk_pulse", {31'd0, chunk_pulse}, 32'd0);
    chk("reset_rd_bank", {31'd0, rd_bank}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_overrun_count", {24'd0, overrun_count}, 32'd0);

    // single chunk 1..64
    p0 = pulses;
    idle(1, 1);
    feed(N, 1, 0);
    idle(3, 1);
    chk("one_chunk_pulses", pulses - p0, 32'd1);
    chk("one_chunk_rd_bank", {31'd0, rd_bank}, 32'd0);

    // 128 back-to-back samples 0..127
    do_reset();
    p0 = pulses;
    idle(1, 1);
    feed(2 * N, 0, 0);
    idle(3, 1);
    chk("two_chunk_pulses", pulses - p0, 32'd2);
    chk("two_chunk_rd_bank", {31'd0, rd_bank}, 32'd1);

    // en dropped mid-chunk, then a full chunk 100..163
    do_reset();
    p0 = pulses;
    idle(1, 1);
    feed(30, 0, 0);
    idle(2, 0);
    idle(1, 1);
    feed(N, 100, 0);
    idle(3, 1);
    chk("en_drop_pulses", pulses - p0, 32'd1);
    chk("en_drop_rd_bank", {31'd0, rd_bank}, 32'd0);

    // reset mid-chunk, then a full chunk
    do_reset();
    p0 = pulses;
    idle(1, 1);
    feed(40, 500, 0);
    step(1, 1, 0, '0, 0);
    idle(1, 1);
    feed(N, 700, 0);
    idle(3, 1);
    chk("rst_mid_pulses", pulses - p0, 32'd1);
    chk("rst_mid_rd_bank", {31'd0, rd_bank}, 32'd0);

    // en falls together with the completing strobe
    do_reset();
    p0 = pulses;
    idle(1, 1);
    feed(N - 1, 900, 0);
    step(0, 0, 1, 24'd999, 0);
    step(0, 1, 1, 24'd5, 0);
    idle(3, 0);
    chk("en_fall_last_pulses", pulses - p0, 32'd1);

    // proc_busy held across 3 completions
    do_reset();
    idle(1, 1);
    feed(3 * N, 0, 1);
    idle(3, 1);
    chk("busy3_overrun", {31'd0, overrun}, OVR_EN ? 32'd1 : 32'd0);
    chk("busy3_overrun_count", {24'd0, overrun_count}, OVR_EN ? 32'd3 : 32'd0);

    // randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 39) != 0,
           $urandom_range(0, 3) != 0, SS'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(3, 1);

    // 300 overrun events saturate the counter
    do_reset();
    idle(1, 1);
    feed(300 * N, 0, 1);
    idle(3, 1);
    chk("sat_overrun", {31'd0, overrun}, OVR_EN ? 32'd1 : 32'd0);
    chk("sat_overrun_count", {24'd0, overrun_count}, OVR_EN ? 32'd255 : 32'd0);

    idle(2, 0);
    chk("pending_expectations", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
